// File: rtl/urng_pair_packer_pkg.sv
// Shared widths, packer state encoding and pair layout for the URNG pair packer.
// A pair is stored as {u0, u1}: the first word plus the top half of the second word form u0.
package urng_pair_packer_pkg;

    localparam int WORD_W = 32;
    localparam int U0_W   = 48;
    localparam int U1_W   = 16;
    localparam int PAIR_W = U0_W + U1_W;

    typedef enum logic {
        WORD0 = 1'b0,
        WORD1 = 1'b1
    } pack_state_e;

    typedef struct packed {
        logic [U0_W-1:0] u0;
        logic [U1_W-1:0] u1;
    } pair_t;

    function automatic pair_t pack_pair(input logic [WORD_W-1:0] first_word,
                                        input logic [WORD_W-1:0] second_word);
        pair_t p;
        p.u0 = {first_word, second_word[WORD_W-1:U1_W]};
        p.u1 = second_word[U1_W-1:0];
        return p;
    endfunction

endpackage

// File: rtl/urng_pair_packer_pair_fifo.sv
// Show-ahead DEPTH x 64 FIFO holding packed operand pairs.
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module pair_fifo
    import urng_pair_packer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  pair_t            wdata,
    output pair_t            rdata,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    pair_t            mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             do_pop_s;
    logic             do_push_s;

    // Qualify requests against occupancy.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign level = level_r;
    assign full  = (level_r == LVL_W'(DEPTH));
    assign empty = (level_r == '0);

endmodule

// File: rtl/urng_pair_packer.sv
// Packs consecutive URNG words into (u0, u1) operand pairs and buffers them for the
// Box-Muller datapath. The source cannot stall, so pairs meeting a full buffer are dropped.
module urng_pair_packer
    import urng_pair_packer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] urng_in,
    input  logic              urng_valid,
    output logic [U0_W-1:0]   u0,
    output logic [U1_W-1:0]   u1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  level,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow
);

    pack_state_e       state_r;
    pack_state_e       state_nx_s;
    logic [WORD_W-1:0] hold_r;
    logic              push_try_s;
    logic              pop_s;
    logic              drop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    pair_t             pair_s;
    pair_t             head_s;
    logic [CNT_W-1:0]  drop_count_r;
    logic              overflow_r;

    // Packer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= WORD0;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Packer next state; a push is attempted when the second word of a pair lands.
    always_comb begin
        state_nx_s = state_r;
        push_try_s = 1'b0;
        case (state_r)
            WORD0: begin
                if (urng_valid) begin
                    state_nx_s = WORD1;
                end else begin
                    state_nx_s = WORD0;
                end
            end
            WORD1: begin
                if (urng_valid) begin
                    state_nx_s = WORD0;
                    push_try_s = 1'b1;
                end else begin
                    state_nx_s = WORD1;
                end
            end
            default: begin
                state_nx_s = WORD0;
                push_try_s = 1'b0;
            end
        endcase
    end

    // First word of a pair waits here for its partner.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_r <= '0;
        end else if ((state_r == WORD0) && urng_valid) begin
            hold_r <= urng_in;
        end else begin
            hold_r <= hold_r;
        end
    end

    // Handshake and drop decision; a same-cycle pop makes room in a full FIFO.
    always_comb begin
        pair_s = pack_pair(hold_r, urng_in);
        pop_s  = out_valid && out_ready;
        drop_s = push_try_s && fifo_full_s && !pop_s;
    end

    pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_try_s),
        .pop   (pop_s),
        .wdata (pair_s),
        .rdata (head_s),
        .level (level),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_r <= '0;
            overflow_r   <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_count_r != {CNT_W{1'b1}}) begin
                drop_count_r <= drop_count_r + CNT_W'(1);
            end
        end
    end

    assign out_valid  = !fifo_empty_s;
    assign u0         = head_s.u0;
    assign u1         = head_s.u1;
    assign drop_count = drop_count_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_urng_pair_packer.sv
// Directed and randomized bench for urng_pair_packer against a queue-based reference model.
module tb_urng_pair_packer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 5;
    localparam int LVL_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       urng_in;
    logic              urng_valid;
    logic              out_ready;
    logic [47:0]       u0;
    logic [15:0]       u1;
    logic              out_valid;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  drop_count;
    logic              overflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] m_q[$];
    bit          m_half;
    logic [31:0] m_hold;
    int          m_drop;
    bit          m_ovf;

    urng_pair_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .urng_in    (urng_in),
        .urng_valid (urng_valid),
        .u0         (u0),
        .u1         (u1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: words pair up in arrival order; a pair enters the queue if there is room
    // after this cycle's pop, otherwise it is counted as dropped.
    task automatic model_edge();
        bit pop;
        if (reset) begin
            m_q.delete();
            m_half = 1'b0;
            m_hold = 32'h0;
            m_drop = 0;
            m_ovf  = 1'b0;
        end else begin
            pop = (m_q.size() != 0) && out_ready;
            if (pop) void'(m_q.pop_front());
            if (urng_valid) begin
                if (!m_half) begin
                    m_hold = urng_in;
                    m_half = 1'b1;
                end else begin
                    m_half = 1'b0;
                    if (m_q.size() < DEPTH) m_q.push_back({m_hold, urng_in});
                    else begin
                        if (m_drop < CMAX) m_drop++;
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("level", 64'(level), 64'(m_q.size()));
        chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (m_q.size() != 0) chk("head_pair", {u0, u1}, m_q[0]);
    endtask

    task automatic step(input logic v, input logic [31:0] w, input logic rdy, input logic rst);
        urng_valid = v;
        urng_in    = w;
        out_ready  = rdy;
        reset      = rst;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        urng_valid = 1'b0;
        urng_in    = 32'h0;
        out_ready  = 1'b0;
        reset      = 1'b1;

        // Reset state.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("reset_u0", 64'(u0), 64'h0);
        chk("reset_u1", 64'(u1), 64'h0);
        chk("reset_out_valid", 64'(out_valid), 64'h0);

        // Back-to-back words; visible right after the second word's edge.
        step(1'b1, 32'h12345678, 1'b1, 1'b0);
        chk("first_no_valid", 64'(out_valid), 64'h0);
        step(1'b1, 32'h9ABCDEF0, 1'b1, 1'b0);
        chk("basic_u0", 64'(u0), 64'h123456789ABC);
        chk("basic_u1", 64'(u1), 64'hDEF0);
        chk("basic_level", 64'(level), 64'h1);
        step(1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);

        // Gapped arrival pairs identically.
        step(1'b1, 32'h12345678, 1'b0, 1'b0);
        step(1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        step(1'b0, 32'hCAFEF00D, 1'b0, 1'b0);
        chk("gap_level", 64'(level), 64'h0);
        step(1'b1, 32'h9ABCDEF0, 1'b0, 1'b0);
        chk("gap_u0", 64'(u0), 64'h123456789ABC);
        chk("gap_u1", 64'(u1), 64'hDEF0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Five pairs into a stalled FIFO: fifth is dropped, then drain in order.
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        chk("full_level", 64'(level), 64'h4);
        chk("full_drop", 64'(drop_count), 64'h1);
        chk("full_ovf", 64'(overflow), 64'h1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drained_level", 64'(level), 64'h0);

        // Full FIFO with pop coinciding with the completing word: no drop.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b1, 1'b0);
        chk("pushpop_level", 64'(level), 64'h4);
        chk("pushpop_drop", 64'(drop_count), 64'h0);
        chk("pushpop_ovf", 64'(overflow), 64'h0);

        // Reset mid-pair discards the held word.
        step(1'b1, 32'h11112222, 1'b0, 1'b0);
        step(1'b1, 32'h33334444, 1'b0, 1'b1);
        chk("midrst_level", 64'(level), 64'h0);
        step(1'b1, 32'hAAAA0000, 1'b0, 1'b0);
        step(1'b1, 32'h5555FFFF, 1'b0, 1'b0);
        chk("midrst_u0", 64'(u0), 64'hAAAA00005555);
        chk("midrst_u1", 64'(u1), 64'hFFFF);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 63) == 0));
        end

        // Drop counter saturation.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 2 * (DEPTH + CMAX + 8); i++) step(1'b1, $urandom, 1'b0, 1'b0);
        chk("sat_drop", 64'(drop_count), 64'(CMAX));
        chk("sat_ovf", 64'(overflow), 64'h1);
        chk("sat_level", 64'(level), 64'(DEPTH));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
